// File: rtl/bootrom_icache_pkg.sv
// Shared types and constants for the boot-RAM instruction cache.
package bootrom_icache_pkg;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Pick 32-bit word `off` out of a 128-bit line (word k sits at [32k+31:32k]).
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        off);
    word_sel = line[32'(off) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/bootrom_icache_if.sv
// Fetch-side request/response and RAM port-B signals of the instruction cache.
// slave: the cache. master: the fetch stage plus the RAM's port B.
interface bootrom_icache_if #(
  parameter int unsigned AW = 14
);
  import bootrom_icache_pkg::*;

  logic              req_valid;
  logic [AW-1:0]     req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_data;
  logic              flush;
  logic              mem_en;
  logic [AW-3:0]     mem_addr;
  logic [LINE_W-1:0] mem_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_data,
    output req_ready, resp_valid, resp_data, mem_en, mem_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_data,
    input  req_ready, resp_valid, resp_data, mem_en, mem_addr
  );

endinterface

// File: rtl/bootrom_icache_tags.sv
// Valid/tag store for the direct-mapped cache: lookup compare, fill update and
// whole-cache flush. A flush in the same cycle as a fill leaves the line invalid.
module bootrom_icache_tags #(
  parameter int unsigned LINES = 16,
  parameter int unsigned AW    = 14
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_fill,
  input  logic [AW-3:0] i_line_addr,
  output logic          o_hit
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - 2 - IW;

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag [LINES];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;

  assign w_idx = i_line_addr[IW-1:0];
  assign w_tag = i_line_addr[AW-3:IW];

  // Valid bits: reset and flush clear everything, flush beats a same-cycle fill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tags need no reset; they are only meaningful while the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  assign o_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

endmodule

// File: rtl/bootrom_icache.sv
// Direct-mapped instruction cache in front of the boot RAM's 128-bit port B.
// Hits return one word per cycle; a miss costs one extra cycle (one line read,
// bypassed straight to the response in the fill cycle).
// Optional feature: define BOOTROM_ICACHE_PERF_EN to build hit/miss counters;
// otherwise o_perf_hits/o_perf_misses are tied to zero.
module bootrom_icache
  import bootrom_icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned AW    = 14
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bootrom_icache_if.slave  io_bus,
  output logic [31:0]      o_perf_hits,
  output logic [31:0]      o_perf_misses
);

  localparam int unsigned IW = $clog2(LINES);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_pend;
  logic [AW-1:0]     r_addr;
  logic [LINE_W-1:0] r_data [LINES];

  logic          w_hit;
  logic          w_accept;
  logic          w_fill;
  logic          w_lookup_hit;
  logic          w_lookup_miss;
  logic [IW-1:0] w_idx;

  assign w_idx         = r_addr[IW+1:2];
  assign w_accept      = io_bus.req_valid && io_bus.req_ready;
  assign w_fill        = (r_state == ST_FILL) && !i_rst;
  assign w_lookup_hit  = (r_state == ST_IDLE) && r_pend && w_hit;
  assign w_lookup_miss = (r_state == ST_IDLE) && r_pend && !w_hit;

  bootrom_icache_tags #(
    .LINES (LINES),
    .AW    (AW)
  ) u_tags (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (io_bus.flush),
    .i_fill      (w_fill),
    .i_line_addr (r_addr[AW-1:2]),
    .o_hit       (w_hit)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a pending miss spends exactly one cycle in FILL.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_lookup_miss) w_state_next = ST_FILL;
      ST_FILL: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; reset forces the quiescent values, abandoning any fill.
  always_comb begin
    io_bus.resp_valid = 1'b0;
    io_bus.resp_data  = '0;
    io_bus.req_ready  = 1'b1;
    io_bus.mem_en     = 1'b0;
    io_bus.mem_addr   = '0;
    if (!i_rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            if (w_hit) begin
              io_bus.resp_valid = 1'b1;
              io_bus.resp_data  = word_sel(r_data[w_idx], r_addr[1:0]);
            end else begin
              io_bus.req_ready = 1'b0;
              io_bus.mem_en    = 1'b1;
              io_bus.mem_addr  = r_addr[AW-1:2];
            end
          end
        end
        ST_FILL: begin
          // RAM output is registered, so the line read issued last cycle is here now.
          io_bus.resp_valid = 1'b1;
          io_bus.resp_data  = word_sel(io_bus.mem_data, r_addr[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Request register: a new accept overrides the completion of the previous one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_pend <= 1'b1;
      r_addr <= io_bus.req_addr;
    end else if (w_lookup_hit || (r_state == ST_FILL)) begin
      r_pend <= 1'b0;
    end
  end

  // Line data store, written from RAM port B in the fill cycle.
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_data[w_idx] <= io_bus.mem_data;
    end
  end

`ifdef BOOTROM_ICACHE_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;

  // Free-running wrap-around hit and FILL-entry counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else begin
      if (w_lookup_hit)  r_perf_hits   <= r_perf_hits + 32'd1;
      if (w_lookup_miss) r_perf_misses <= r_perf_misses + 32'd1;
    end
  end

  assign o_perf_hits   = r_perf_hits;
  assign o_perf_misses = r_perf_misses;
`else
  assign o_perf_hits   = '0;
  assign o_perf_misses = '0;
`endif

endmodule

// File: tb/tb_bootrom_icache.sv
// Self-checking bench for bootrom_icache: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level cache model.
module tb_bootrom_icache;
  import bootrom_icache_pkg::*;

  localparam int unsigned LINES = 16;
  localparam int unsigned AW    = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  always #5 clk = ~clk;

  bootrom_icache_if #(.AW(AW)) bus ();

  bootrom_icache #(
    .LINES (LINES),
    .AW    (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .io_bus        (bus),
    .o_perf_hits   (perf_hits),
    .o_perf_misses (perf_misses)
  );

  // Boot RAM contents: word k of line l; line 0x004 word 0 is 0xDEADBEEF.
  function automatic logic [31:0] rom_word(input int unsigned line, input int unsigned k);
    if (line == 4 && k == 0) return 32'hDEADBEEF;
    return (line * 32'h9E3779B1) ^ (k * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  // RAM port B: registered read, one cycle latency.
  always @(posedge clk) begin : rom_b
    logic [127:0] t;
    if (bus.mem_en) begin
      for (int k = 0; k < 4; k++) t[32*k +: 32] = rom_word(32'(bus.mem_addr), k);
      bus.mem_data <= t;
    end
  end

  // Model state: cache directory plus the one request awaiting lookup / fill.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  bit          m_pend;
  int unsigned m_pend_addr;
  bit          m_fill;
  int unsigned m_fill_addr;
  int unsigned m_hits;
  int unsigned m_misses;
  int unsigned exp_pulses;
  int unsigned obs_pulses;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input int unsigned a);
    int unsigned idx = (a / 4) % LINES;
    return m_valid[idx] && (m_tag[idx] == a / (4 * LINES));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_pend   = 1'b0;
    m_fill   = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_perf();
    int unsigned eh, em;
`ifdef BOOTROM_ICACHE_PERF_EN
    eh = m_hits;
    em = m_misses;
`else
    eh = 0;
    em = 0;
`endif
    check_eq("perf_hits", perf_hits, eh);
    check_eq("perf_misses", perf_misses, em);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input logic v, input int unsigned a, input logic f);
    logic        e_rv, e_ready, e_men, lk_hit, lk_miss;
    logic [31:0] e_rd;
    int unsigned e_maddr;
    bit          accept;
    bus.req_valid = v;
    bus.req_addr  = AW'(a);
    bus.flush     = f;
    #1;
    e_rv = 0; e_rd = 0; e_ready = 1; e_men = 0; e_maddr = 0; lk_hit = 0; lk_miss = 0;
    if (m_fill) begin
      e_rv = 1;
      e_rd = rom_word(m_fill_addr / 4, m_fill_addr % 4);
    end else if (m_pend) begin
      if (model_hit(m_pend_addr)) begin
        lk_hit = 1;
        e_rv   = 1;
        e_rd   = rom_word(m_pend_addr / 4, m_pend_addr % 4);
      end else begin
        lk_miss = 1;
        e_ready = 0;
        e_men   = 1;
        e_maddr = m_pend_addr / 4;
      end
    end
    check_eq("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    if (e_rv) check_eq("resp_data", bus.resp_data, e_rd);
    check_eq("req_ready", 32'(bus.req_ready), 32'(e_ready));
    check_eq("mem_en", 32'(bus.mem_en), 32'(e_men));
    if (e_men) check_eq("mem_addr", 32'(bus.mem_addr), e_maddr);
    check_perf();
    if (bus.mem_en) obs_pulses++;
    // Advance the model across the coming clock edge.
    accept = v && e_ready;
    if (m_fill) begin
      m_valid[(m_fill_addr / 4) % LINES] = 1'b1;
      m_tag[(m_fill_addr / 4) % LINES]   = m_fill_addr / (4 * LINES);
    end
    if (f) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    if (lk_hit) m_hits++;
    if (lk_miss) begin
      m_misses++;
      exp_pulses++;
    end
    m_fill      = lk_miss;
    m_fill_addr = m_pend_addr;
    m_pend      = accept;
    m_pend_addr = a;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("rst_resp_data", bus.resp_data, 32'd0);
      check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic req_wait(input int unsigned a);
    tick(1'b1, a, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b0);
  endtask

  initial begin
    int unsigned base;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    exp_pulses    = 0;
    obs_pulses    = 0;
    model_clear();
    @(negedge clk);
    do_reset(2);

    // Cold miss on 0x0010, then words 1..3 of the same line back to back.
    base = obs_pulses;
    tick(1'b1, 'h10, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 'h11, 1'b0);
    tick(1'b1, 'h12, 1'b0);
    tick(1'b1, 'h13, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0);
    check_eq("s1_mem_pulses", obs_pulses - base, 32'd1);
`ifdef BOOTROM_ICACHE_PERF_EN
    check_eq("s1_perf_misses", perf_misses, 32'd1);
    check_eq("s1_perf_hits", perf_hits, 32'd3);
`endif

    // Conflicting tags on one index.
    do_reset(1);
    base = obs_pulses;
    req_wait('h10);
    req_wait('h110);
    req_wait('h10);
    check_eq("s3_mem_pulses", obs_pulses - base, 32'd3);

    // Flush after fill forces a fresh miss.
    req_wait('h10);
    tick(1'b0, 0, 1'b1);
    base = obs_pulses;
    req_wait('h10);
    check_eq("s4_mem_pulses", obs_pulses - base, 32'd1);

    // Flush in the FILL cycle: response still delivered, line left invalid.
    base = obs_pulses;
    tick(1'b1, 'h20, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1);
    req_wait('h21);
    check_eq("s5_mem_pulses", obs_pulses - base, 32'd2);

    // Back-to-back misses, and a same-line request accepted in the FILL cycle.
    tick(1'b1, 'h40, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 'h80, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 'h81, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0);

    // Reset in the FILL cycle abandons the fill.
    tick(1'b1, 'h150, 1'b0);
    tick(1'b0, 0, 1'b0);
    do_reset(1);
    tick(1'b0, 0, 1'b0);
    check_eq("rst_fill_perf_hits", perf_hits, 32'd0);
    check_eq("rst_fill_perf_misses", perf_misses, 32'd0);

    // Random traffic over a small address window so hits, aliases and flushes mix.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) << 6) | $urandom_range(0, 63),
           $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b0);
    check_eq("total_mem_pulses", obs_pulses, exp_pulses);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bootrom_icache.md
# bootrom_icache

Direct-mapped instruction cache between the core's fetch stage and the boot RAM's 128-bit read-only port. It serves one 32-bit word per cycle on hits and fills a whole 4-word line on a miss with a single line read. It drives the RAM's port-B address and clock enable, and consumes port B's registered 128-bit output one cycle later. Port A of the RAM, the 32-bit data side, is not touched.

## Interface
Parameters:
- `LINES`, 16: number of cache lines. Power of two, 2..256.
- `AW`, 14: word-address width. Line address width is `AW-2`.

Ports:
- `clk`, in, 1: single clock for the cache and RAM port B.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: fetch request.
- `req_addr`, in, AW: word address.
- `req_ready`, out, 1: cache can accept a request this cycle.
- `resp_valid`, out, 1: `resp_data` is valid. No backpressure; the consumer must take it.
- `resp_data`, out, 32: fetched instruction word.
- `flush`, in, 1: invalidate all lines.
- `mem_en`, out, 1: port-B clock enable.
- `mem_addr`, out, AW-2: port-B line address.
- `mem_data`, in, 128: port-B data. Word k is `[32k+31:32k]`.
- `perf_hits`, out, 32: hit counter (see Configuration).
- `perf_misses`, out, 32: miss counter (see Configuration).

## Operation
Address split:
- offset = `req_addr[1:0]`
- index = `req_addr[1+log2(LINES):2]`
- tag = remaining upper bits

Storage:
- Flop arrays: `valid[LINES]`, `tag[LINES]`, `data[LINES]` (128 bits each).

Accept:
- A request is accepted when `req_valid && req_ready`.
- Its address is registered into `r_addr` and `r_pend` is set.

FSM `IDLE -> FILL -> IDLE`:
- IDLE, `r_pend=1`, hit (valid and tag match):
  - `resp_valid=1`, `resp_data=data[index]` word offset.
  - `req_ready=1`, so back-to-back hits run at one per cycle.
- IDLE, `r_pend=1`, miss:
  - `resp_valid=0`, `req_ready=0`.
  - `mem_en=1`, `mem_addr=r_addr[AW-1:2]`.
  - Next state FILL.
- FILL:
  - Writes `mem_data` into `data[index]`, sets `tag[index]` and `valid[index]`.
  - `resp_valid=1` with the word bypassed directly from `mem_data`.
  - `req_ready=1`. Next state IDLE.
- IDLE, `r_pend=0`: `req_ready=1`, `mem_en=0`.

Flush:
- Clears all valid bits at the clock edge.
- A hit or fill completing in the same cycle still returns its data.
- If a flush coincides with the FILL cycle, the filled line is written but left invalid (flush wins).
- Requests are accepted normally during a flush.

Reset:
- Resets state to IDLE and clears `r_pend` and all valid bits.
- Output values under reset: `resp_valid=0`, `resp_data=0`, `mem_en=0`, `mem_addr=0`, `req_ready=1`, perf counters 0.
- Reset during FILL abandons the fill with no response.

## Timing
- Request accepted at cycle N.
- Hit: response in cycle N+1.
- Miss:
  - N+1: `mem_en` pulse.
  - N+2: RAM output valid; response in N+2.
- Miss penalty is 1 cycle. `req_ready` is low only in cycle N+1.
- `mem_en` is high for exactly one cycle per miss.
- Consecutive misses to different lines produce responses at N+2 and N+4.
- A request accepted in the FILL cycle for the same line hits in the next cycle.

## Configuration
- `BOOTROM_ICACHE_PERF_EN` defined:
  - `perf_hits` counts cycles with IDLE and a hit.
  - `perf_misses` counts FILL entries.
  - Both are 32-bit, wrap from `0xFFFFFFFF` to 0, and clear on `rst`.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `bootrom_icache_pkg` holds:
  - FSM state enum (`ST_IDLE`, `ST_FILL`)
  - `LINE_W=128`, `WORD_W=32`, `WORDS_PER_LINE=4`
- One sub-module, `bootrom_icache_tags`:
  - Holds the valid and tag arrays, compare logic, and flush clear.
  - Outputs `hit`.

## Test plan
- Reset, then request 0x0010:
  - `mem_en` pulses with `mem_addr=0x004` at N+1.
  - `mem_data` word0 is 0xDEADBEEF, so at N+2 `resp_data=0xDEADBEEF`.
- Then requests 0x0011, 0x0012, 0x0013 back-to-back:
  - Three responses on consecutive cycles from the line's words 1..3.
  - No `mem_en` activity.
- Request 0x0010, then 0x0110 (same index with `LINES=16`, different tag), then 0x0010:
  - Three misses.
  - Three `mem_en` pulses with line addresses 0x004, 0x044, 0x004.
- Fill line 0x004, assert `flush` for one cycle, request 0x0010:
  - Miss with a fresh `mem_en` pulse.
- Assert `flush` in the FILL cycle of 0x0020, then request 0x0021:
  - Response to 0x0020 is still delivered.
  - 0x0021 misses.
- `BOOTROM_ICACHE_PERF_EN` defined: after the first two scenarios, `perf_misses=1` and `perf_hits=3`.
  - Assert `rst` mid-FILL: `resp_valid` stays 0 and both counters read 0.
